// File: rtl/midi_voice_alloc_if.sv
// midi_voice_alloc_if: MIDI byte input and per-voice note/velocity/gate outputs
// of the stepper voice allocator.
interface midi_voice_alloc_if #(parameter int NUM_VOICES = 8);
   logic                    ByteValid;
   logic [7:0]              ByteIn;
   logic [3:0]              ChanSel;
   logic                    OmniEn;
   logic [7*NUM_VOICES-1:0] VoiceNote;
   logic [7*NUM_VOICES-1:0] VoiceVel;
   logic [NUM_VOICES-1:0]   VoiceGate;
   logic                    StealPulse;
   modport master (output ByteValid, ByteIn, ChanSel, OmniEn,
                   input VoiceNote, VoiceVel, VoiceGate, StealPulse);
   modport slave (input ByteValid, ByteIn, ChanSel, OmniEn,
                  output VoiceNote, VoiceVel, VoiceGate, StealPulse);
endinterface

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: running-status MIDI parser feeding an LRU stepper voice allocator.
// A completed message passes two register stages before the voice pool updates.
module midi_voice_alloc #(
   parameter int NUM_VOICES = 8,
   parameter int AGE_W = 4
) (
   input logic Clk,
   input logic Rst_n,
   midi_voice_alloc_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam logic [AGE_W-1:0] AGE_MAX = '1;
   typedef enum logic [2:0] {S_STATUS, S_D1, S_D2, S_SKIP1, S_SKIP2} state_t;
   typedef enum logic [1:0] {K_NONE, K_ON, K_OFF, K_ALL_OFF} kind_t;
   state_t state, state_nxt;
   kind_t kind, p1_kind, p2_kind;
   logic [7:0] run_stat;
   logic [3:0] hi;
   logic run_valid, is_sys, is_stat, is_data, stat_one, run_one, chan_ok, d1_we, done;
   logic [6:0] d1, p1_note, p1_vel, p2_note, p2_vel;
   logic [6:0] note [NUM_VOICES];
   logic [6:0] vel [NUM_VOICES];
   logic [AGE_W-1:0] age [NUM_VOICES];
   logic [NUM_VOICES-1:0] gate;
   logic steal, hit, free, bump_all;
   logic [IDX_W-1:0] hit_idx, free_idx, old_idx, tgt;

   // Realtime bytes (F8-FF) match none of these and so leave the parser untouched.
   assign is_sys = bus.ByteValid && bus.ByteIn[7:3] == 5'b11110;
   assign is_stat = bus.ByteValid && bus.ByteIn[7] && bus.ByteIn[7:4] != 4'hF;
   assign is_data = bus.ByteValid && !bus.ByteIn[7];
   assign stat_one = bus.ByteIn[7:5] == 3'b110;
   assign run_one = run_stat[7:5] == 3'b110;
   assign hi = run_stat[7:4];
   assign chan_ok = bus.OmniEn || run_stat[3:0] == bus.ChanSel;

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) state <= S_STATUS;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (is_sys) state_nxt = S_STATUS;
      else if (is_stat) state_nxt = stat_one ? S_SKIP1 : S_D1;
      else if (is_data)
         case (state)
            S_STATUS: state_nxt = !run_valid ? S_STATUS : run_one ? S_SKIP1 : S_D2;
            S_D1: state_nxt = S_D2;
            S_D2: state_nxt = S_D1;
            default: state_nxt = S_SKIP1;
         endcase
   end

   always_comb begin
      d1_we = is_data && (state == S_D1 || (state == S_STATUS && run_valid && !run_one));
      done = is_data && state == S_D2;
   end

   always_comb
      kind = !(done && chan_ok) ? K_NONE :
             hi == 4'h9 && bus.ByteIn[6:0] != 7'd0 ? K_ON :
             hi == 4'h8 || hi == 4'h9 ? K_OFF :
             hi == 4'hB && (d1 == 7'h7B || d1 == 7'h78) ? K_ALL_OFF : K_NONE;

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         run_stat <= '0;
         run_valid <= 1'b0;
         d1 <= '0;
         p1_kind <= K_NONE;
         p1_note <= '0;
         p1_vel <= '0;
         p2_kind <= K_NONE;
         p2_note <= '0;
         p2_vel <= '0;
      end else begin
         if (is_sys) run_valid <= 1'b0;
         if (is_stat) begin
            run_stat <= bus.ByteIn;
            run_valid <= 1'b1;
         end
         if (d1_we) d1 <= bus.ByteIn[6:0];
         p1_kind <= kind;
         p1_note <= d1;
         p1_vel <= bus.ByteIn[6:0];
         p2_kind <= p1_kind;
         p2_note <= p1_note;
         p2_vel <= p1_vel;
      end

   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      free = 1'b0;
      free_idx = '0;
      old_idx = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (gate[i] && note[i] == p2_note) begin
            hit = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!gate[i]) begin
            free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
      for (int i = 1; i < NUM_VOICES; i++)
         if (age[i] > age[old_idx]) old_idx = IDX_W'(i);
      tgt = hit ? hit_idx : free ? free_idx : old_idx;
      bump_all = !gate[tgt];
   end

   // A silent voice counts as older than every other, so allocating it ages the whole pool.
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         gate <= '0;
         steal <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note[i] <= '0;
            vel[i] <= '0;
            age[i] <= '0;
         end
      end else begin
         steal <= p2_kind == K_ON && !hit && !free;
         if (p2_kind == K_ON) begin
            for (int i = 0; i < NUM_VOICES; i++)
               if (IDX_W'(i) == tgt) begin
                  note[i] <= p2_note;
                  vel[i] <= p2_vel;
                  gate[i] <= 1'b1;
                  age[i] <= '0;
               end else if ((bump_all || age[i] < age[tgt]) && age[i] != AGE_MAX)
                  age[i] <= age[i] + 1'b1;
         end else if (p2_kind == K_OFF) begin
            for (int i = 0; i < NUM_VOICES; i++)
               if (gate[i] && note[i] == p2_note) gate[i] <= 1'b0;
         end else if (p2_kind == K_ALL_OFF)
            gate <= '0;
      end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
      assign bus.VoiceNote[7*v +: 7] = note[v];
      assign bus.VoiceVel[7*v +: 7] = vel[v];
   end
   assign bus.VoiceGate = gate;
   assign bus.StealPulse = steal;
endmodule

// File: tb/tb_midi_voice_alloc.sv
// tb_midi_voice_alloc: directed vector table, reset sequences and random byte streams,
// all checked every cycle against a message-level model of the voice pool.
module tb_midi_voice_alloc;
   localparam int NV = 8;
   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   midi_voice_alloc_if #(.NUM_VOICES(NV)) bus ();
   midi_voice_alloc #(.NUM_VOICES(NV), .AGE_W(4)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;

   typedef struct {int kind; int note; int vel;} msg_t;
   int m_rs;
   byte unsigned m_dq[$];
   int m_note[NV], m_vel[NV], m_gate[NV], m_age[NV];
   bit m_steal;
   msg_t m_p1, m_p2;

   typedef struct {
      logic [63:0] bs;
      int n;
      logic [3:0] chan;
      logic omni;
      logic [7:0] gate;
      int vi;
      logic [6:0] note, vel;
      logic steal;
   } vec_t;
   vec_t vt[$];

   task automatic m_reset();
      m_rs = -1;
      m_dq.delete();
      for (int i = 0; i < NV; i++) begin
         m_note[i] = 0;
         m_vel[i] = 0;
         m_gate[i] = 0;
         m_age[i] = 0;
      end
      m_steal = 0;
      m_p1 = '{0, 0, 0};
      m_p2 = '{0, 0, 0};
   endtask

   // Byte stream -> channel message, tracked as a running status plus collected data bytes.
   task automatic m_parse(input byte unsigned b, input logic [3:0] cs, input logic om, output msg_t m);
      int len;
      m = '{0, 0, 0};
      if (b >= 8'hF8) return;
      if (b >= 8'hF0) begin
         m_rs = -1;
         m_dq.delete();
         return;
      end
      if (b >= 8'h80) begin
         m_rs = b;
         m_dq.delete();
         return;
      end
      if (m_rs < 0) return;
      m_dq.push_back(b);
      len = (m_rs / 16 == 12 || m_rs / 16 == 13) ? 1 : 2;
      if (m_dq.size() < len) return;
      if (len == 2 && (om || m_rs % 16 == int'(cs))) begin
         if (m_rs / 16 == 9 && m_dq[1] != 0) m = '{1, m_dq[0], m_dq[1]};
         else if (m_rs / 16 == 8 || m_rs / 16 == 9) m = '{2, m_dq[0], 0};
         else if (m_rs / 16 == 11 && (m_dq[0] == 8'h7B || m_dq[0] == 8'h78)) m = '{3, 0, 0};
      end
      m_dq.delete();
   endtask

   task automatic m_apply(input msg_t m);
      int v, prev;
      m_steal = 0;
      if (m.kind == 1) begin
         v = -1;
         for (int i = NV - 1; i >= 0; i--) if (m_gate[i] != 0 && m_note[i] == m.note) v = i;
         if (v < 0) for (int i = NV - 1; i >= 0; i--) if (m_gate[i] == 0) v = i;
         if (v < 0) begin
            v = 0;
            for (int i = 0; i < NV; i++) if (m_age[i] > m_age[v]) v = i;
            m_steal = 1;
         end
         prev = m_gate[v] != 0 ? m_age[v] : 1000;
         for (int i = 0; i < NV; i++)
            if (i != v && m_age[i] < prev) m_age[i] = m_age[i] < 15 ? m_age[i] + 1 : 15;
         m_age[v] = 0;
         m_note[v] = m.note;
         m_vel[v] = m.vel;
         m_gate[v] = 1;
      end else if (m.kind == 2) begin
         for (int i = 0; i < NV; i++) if (m_gate[i] != 0 && m_note[i] == m.note) m_gate[i] = 0;
      end else if (m.kind == 3) begin
         for (int i = 0; i < NV; i++) m_gate[i] = 0;
      end
   endtask

   task automatic check_model();
      logic [7*NV-1:0] en, ev;
      logic [NV-1:0] eg;
      for (int i = 0; i < NV; i++) begin
         en[7*i +: 7] = 7'(m_note[i]);
         ev[7*i +: 7] = 7'(m_vel[i]);
         eg[i] = m_gate[i] != 0;
      end
      tests++;
      if (bus.VoiceNote !== en || bus.VoiceVel !== ev || bus.VoiceGate !== eg || bus.StealPulse !== m_steal) begin
         fails++;
         $display("FAIL model t=%0t note=%h want %h vel=%h want %h gate=%h want %h steal=%b want %b",
                  $time, bus.VoiceNote, en, bus.VoiceVel, ev, bus.VoiceGate, eg, bus.StealPulse, m_steal);
      end
   endtask

   task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input logic v, input logic [7:0] b);
      msg_t nm;
      bus.ByteValid = v;
      bus.ByteIn = b;
      @(posedge Clk);
      m_apply(m_p2);
      m_p2 = m_p1;
      if (v) m_parse(b, bus.ChanSel, bus.OmniEn, nm);
      else nm = '{0, 0, 0};
      m_p1 = nm;
      #1;
      bus.ByteValid = 1'b0;
      check_model();
   endtask

   function automatic vec_t mk(input logic [63:0] b, input int n, input logic [3:0] ch, input logic om,
                               input logic [7:0] g, input int vi, input logic [6:0] nt, input logic [6:0] vl,
                               input logic st);
      vec_t r;
      r.bs = b << (64 - 8 * n);
      r.n = n;
      r.chan = ch;
      r.omni = om;
      r.gate = g;
      r.vi = vi;
      r.note = nt;
      r.vel = vl;
      r.steal = st;
      return r;
   endfunction

   function automatic logic [7:0] rand_byte();
      int r = $urandom_range(0, 99);
      int d;
      logic [3:0] t;
      logic [3:0] types [9] = '{4'h8, 4'h9, 4'h9, 4'h9, 4'hB, 4'hA, 4'hC, 4'hD, 4'hE};
      if (r < 8) return 8'hF8 + 8'($urandom_range(0, 7));
      if (r < 11) return 8'hF0 + 8'($urandom_range(0, 7));
      if (r < 40) begin
         t = types[$urandom_range(0, 8)];
         return {t, 4'($urandom_range(0, 3))};
      end
      d = $urandom_range(0, 9);
      if (d < 6) return 8'h3C + 8'($urandom_range(0, 11));
      if (d < 8) return 8'($urandom_range(0, 2));
      return d == 8 ? 8'h7B : 8'h78;
   endfunction

   initial begin
      bus.ByteValid = 1'b0;
      bus.ByteIn = '0;
      bus.ChanSel = '0;
      bus.OmniEn = 1'b0;
      m_reset();
      repeat (2) @(posedge Clk);
      #1;
      expect_eq("reset gate", 64'(bus.VoiceGate), 0);
      expect_eq("reset note", 64'(bus.VoiceNote), 0);
      expect_eq("reset vel", 64'(bus.VoiceVel), 0);
      expect_eq("reset steal", 64'(bus.StealPulse), 0);
      Rst_n = 1'b1;
      check_model();

      vt.push_back(mk(64'h903C64, 3, 0, 0, 8'h01, 0, 7'h3C, 7'h64, 0));
      vt.push_back(mk(64'h4050, 2, 0, 0, 8'h03, 1, 7'h40, 7'h50, 0));
      vt.push_back(mk(64'h903C00, 3, 0, 0, 8'h02, 0, 7'h3C, 7'h64, 0));
      vt.push_back(mk(64'h80407F, 3, 0, 0, 8'h00, 1, 7'h40, 7'h50, 0));
      vt.push_back(mk(64'h804100, 3, 0, 0, 8'h00, 1, 7'h40, 7'h50, 0));
      for (int k = 0; k < 8; k++)
         vt.push_back(mk(64'h900064 | (64'(8'h3C + k) << 8), 3, 0, 0, 8'((1 << (k + 1)) - 1), k,
                         7'(8'h3C + k), 7'h64, 0));
      vt.push_back(mk(64'h904464, 3, 0, 0, 8'hFF, 0, 7'h44, 7'h64, 1));
      vt.push_back(mk(64'h903D70, 3, 0, 0, 8'hFF, 1, 7'h3D, 7'h70, 0));
      vt.push_back(mk(64'h904564, 3, 0, 0, 8'hFF, 2, 7'h45, 7'h64, 1));
      vt.push_back(mk(64'hB07800, 3, 0, 0, 8'h00, 2, 7'h45, 7'h64, 0));
      vt.push_back(mk(64'h913C64, 3, 2, 0, 8'h00, 0, 7'h44, 7'h64, 0));
      vt.push_back(mk(64'hC205, 2, 2, 0, 8'h00, 0, 7'h44, 7'h64, 0));
      vt.push_back(mk(64'h923C64, 3, 2, 0, 8'h01, 0, 7'h3C, 7'h64, 0));
      vt.push_back(mk(64'h913E64, 3, 2, 1, 8'h03, 1, 7'h3E, 7'h64, 0));
      vt.push_back(mk(64'h90F83FF864, 5, 0, 0, 8'h07, 2, 7'h3F, 7'h64, 0));
      vt.push_back(mk(64'h903CF040, 4, 0, 0, 8'h07, 0, 7'h3C, 7'h64, 0));
      vt.push_back(mk(64'h4064, 2, 0, 0, 8'h07, 0, 7'h3C, 7'h64, 0));
      vt.push_back(mk(64'h905064, 3, 0, 0, 8'h0F, 3, 7'h50, 7'h64, 0));
      vt.push_back(mk(64'hB00764, 3, 0, 0, 8'h0F, 3, 7'h50, 7'h64, 0));
      vt.push_back(mk(64'hB07B00, 3, 0, 0, 8'h00, 3, 7'h50, 7'h64, 0));

      foreach (vt[k]) begin
         logic [7:0] gb;
         bus.ChanSel = vt[k].chan;
         bus.OmniEn = vt[k].omni;
         gb = bus.VoiceGate;
         for (int j = 0; j < vt[k].n; j++) tick(1'b1, vt[k].bs[63-8*j -: 8]);
         tick(1'b0, 8'h00);
         expect_eq($sformatf("vec%0d gate one edge after last byte", k), 64'(bus.VoiceGate), 64'(gb));
         tick(1'b0, 8'h00);
         expect_eq($sformatf("vec%0d gate", k), 64'(bus.VoiceGate), 64'(vt[k].gate));
         expect_eq($sformatf("vec%0d note", k), 64'(bus.VoiceNote[7*vt[k].vi +: 7]), 64'(vt[k].note));
         expect_eq($sformatf("vec%0d vel", k), 64'(bus.VoiceVel[7*vt[k].vi +: 7]), 64'(vt[k].vel));
         expect_eq($sformatf("vec%0d steal", k), 64'(bus.StealPulse), 64'(vt[k].steal));
         tick(1'b0, 8'h00);
         expect_eq($sformatf("vec%0d steal width", k), 64'(bus.StealPulse), 0);
      end

      // Reset with one message still in the pipeline and another half received.
      bus.ChanSel = 4'h0;
      bus.OmniEn = 1'b0;
      tick(1'b1, 8'h90);
      tick(1'b1, 8'h3E);
      tick(1'b1, 8'h64);
      tick(1'b1, 8'h90);
      Rst_n = 1'b0;
      m_reset();
      #2;
      expect_eq("async reset gate", 64'(bus.VoiceGate), 0);
      expect_eq("async reset note", 64'(bus.VoiceNote), 0);
      expect_eq("async reset vel", 64'(bus.VoiceVel), 0);
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      Rst_n = 1'b1;
      tick(1'b1, 8'h3C);
      tick(1'b1, 8'h64);
      repeat (3) tick(1'b0, 8'h00);
      expect_eq("orphan data after reset gate", 64'(bus.VoiceGate), 0);
      expect_eq("orphan data after reset note", 64'(bus.VoiceNote), 0);

      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) begin
            bus.ChanSel = 4'($urandom_range(0, 3));
            bus.OmniEn = $urandom_range(0, 3) == 0;
         end
         if ($urandom_range(0, 599) == 0) begin
            Rst_n = 1'b0;
            m_reset();
            #2;
            check_model();
            Rst_n = 1'b1;
         end
         tick($urandom_range(0, 3) != 0, rand_byte());
      end
      repeat (3) tick(1'b0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
